// File: rtl/fnd_pkg.sv
// Shared definitions for the FND scan controller: conversion FSM encoding,
// digit geometry and the combinational helpers used by the datapath and the
// blanking logic.
package fnd_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int BCD_W       = 4;
  localparam int VALUE_W     = 14;
  localparam int MAX_VALUE   = 9999;
  localparam int CONV_CYCLES = 14;

  localparam int CNT_W  = $clog2(CONV_CYCLES);
  localparam int BCD_TW = NUM_DIGITS * BCD_W;
  localparam int SR_W   = BCD_TW + VALUE_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_UPDATE = 2'd2
  } conv_state_t;

  typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] bcd_digits_t;

  // Clamp a captured value to the largest number four digits can show.
  function automatic logic [VALUE_W-1:0] saturate(input logic [VALUE_W-1:0] v);
    return (v > VALUE_W'(MAX_VALUE)) ? VALUE_W'(MAX_VALUE) : v;
  endfunction

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
  // the whole {bcd, binary} register left by one.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (t[VALUE_W + k*BCD_W +: BCD_W] >= BCD_W'(5))
        t[VALUE_W + k*BCD_W +: BCD_W] = t[VALUE_W + k*BCD_W +: BCD_W] + BCD_W'(3);
    end
    return t << 1;
  endfunction

  // Digit idx is a leading zero when it and every higher digit are zero.
  // The ones digit is never blanked so that zero still shows "0".
  function automatic logic lz_blank(input bcd_digits_t d, input logic [1:0] idx);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx))
        upper_zero = upper_zero & (d[i] == '0);
    end
    return (idx != 2'd0) && upper_zero;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per clock.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for i_start; captures the saturated value
//   ST_CONV   | CONV_CYCLES shift-add-3 iterations, r_cnt counts down to 0
//   ST_UPDATE | o_done high for one cycle; the top copies o_bcd to display
//
// o_busy is high in ST_CONV and ST_UPDATE only. i_start outside ST_IDLE is
// dropped, not queued.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [VALUE_W-1:0] i_value,
  output logic               o_busy,
  output logic               o_done,
  output bcd_digits_t        o_bcd
);

  conv_state_t      r_state;
  logic [SR_W-1:0]  r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  // Conversion FSM with registered busy/done flags.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_shift <= {{BCD_TW{1'b0}}, saturate(i_value)};
            r_cnt   <= CNT_W'(CONV_CYCLES - 1);
            r_state <= ST_CONV;
            r_busy  <= 1'b1;
          end
        end
        ST_CONV: begin
          r_shift <= dabble_step(r_shift);
          if (r_cnt == '0) begin
            r_state <= ST_UPDATE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_UPDATE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_bcd  = r_shift[SR_W-1 -: BCD_TW];

endmodule

// File: rtl/fnd_scan_controller.sv
// Four-digit seven-segment scan controller: converts a captured binary value
// to BCD, holds it in display registers and time-multiplexes the digits with
// optional leading-zero blanking. The scan runs freely; new display contents
// reach the outputs at the next digit advance so the scan phase never jumps.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int PRESCALE = 100000,
  parameter int LZ_BLANK = 1
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_load,
  input  logic               i_blank,
  output logic               o_busy,
  output logic [1:0]         o_DigitSelect,
  output logic               o_blank,
  output logic [BCD_W-1:0]   o_bcd
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic              w_busy;
  logic              w_done;
  bcd_digits_t       w_conv_bcd;
  logic              w_tick;
  logic [1:0]        w_digit_next;
  logic              w_lz_next;

  bcd_digits_t       r_disp;
  logic [PW-1:0]     r_presc;
  logic [1:0]        r_digit;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_lz_slot;
  logic              r_blank;

  bin2bcd_seq u_bin2bcd (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (i_load),
    .i_value   (i_value),
    .o_busy    (w_busy),
    .o_done    (w_done),
    .o_bcd     (w_conv_bcd)
  );

  assign w_tick       = (r_presc == PW'(PRESCALE - 1));
  assign w_digit_next = r_digit + 2'd1;
  assign w_lz_next    = (LZ_BLANK != 0) && lz_blank(r_disp, w_digit_next);

  // Display registers take the converter result during its update cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      r_disp <= '0;
    else if (w_done)
      r_disp <= w_conv_bcd;
  end

  // Free-running slot prescaler, wraps at PRESCALE-1.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      r_presc <= '0;
    else if (w_tick)
      r_presc <= '0;
    else
      r_presc <= r_presc + PW'(1);
  end

  // Digit index, BCD value and slot blank flag advance together on each tick
  // so o_bcd and o_DigitSelect always describe the same digit.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_digit   <= 2'd0;
      r_bcd     <= '0;
      r_lz_slot <= 1'b0;
    end else if (w_tick) begin
      r_digit   <= w_digit_next;
      r_bcd     <= r_disp[w_digit_next];
      r_lz_slot <= w_lz_next;
    end
  end

  // Blank output re-registered every cycle so i_blank acts within one clock.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      r_blank <= 1'b1;
    else
      r_blank <= i_blank | (w_tick ? w_lz_next : r_lz_slot);
  end

  assign o_busy        = w_busy;
  assign o_DigitSelect = r_digit;
  assign o_bcd         = r_bcd;
  assign o_blank       = r_blank;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller with PRESCALE=4. Expected digit slots are
// pushed to a queue when a value is loaded and popped as the scan presents
// each digit.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        i_reset_n;
  logic [13:0] i_value;
  logic        i_load;
  logic        i_blank;
  logic        o_busy;
  logic [1:0]  o_DigitSelect;
  logic        o_blank;
  logic [3:0]  o_bcd;

  always #5 clk = ~clk;

  fnd_scan_controller #(.PRESCALE(4), .LZ_BLANK(1)) dut (
    .i_clk         (clk),
    .i_reset_n     (i_reset_n),
    .i_value       (i_value),
    .i_load        (i_load),
    .i_blank       (i_blank),
    .o_busy        (o_busy),
    .o_DigitSelect (o_DigitSelect),
    .o_blank       (o_blank),
    .o_bcd         (o_bcd)
  );

  typedef struct {
    int sel;
    int bcd;
    int blank;
  } slot_t;

  slot_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected slots for a loaded value: decimal digits, ones first; digit d>0
  // is a leading zero exactly when the value is below 10**d.
  task automatic push_expected(input int v);
    int sat;
    int pw;
    slot_t e;
    sat = (v > 9999) ? 9999 : v;
    pw  = 1;
    for (int d = 0; d < 4; d++) begin
      e.sel   = d;
      e.bcd   = (sat / pw) % 10;
      e.blank = (d > 0 && sat < pw) ? 1 : 0;
      exp_q.push_back(e);
      pw = pw * 10;
    end
  endtask

  // Pulse i_load with v and count busy cycles; optionally strobe a second
  // load of inj_v on busy cycle inj_at.
  task automatic load_value(input int v, input int inj_at, input int inj_v,
                            output int busy_len);
    @(negedge clk);
    i_value = v[13:0];
    i_load  = 1'b1;
    @(negedge clk);
    i_load  = 1'b0;
    busy_len = 0;
    while (o_busy === 1'b1 && busy_len < 40) begin
      busy_len++;
      if (busy_len == inj_at) begin
        i_value = inj_v[13:0];
        i_load  = 1'b1;
      end
      @(negedge clk);
      i_load = 1'b0;
    end
  endtask

  // Align to the next scan wrap to digit 0, then pop and compare four slots
  // and confirm the scan wraps back to 0.
  task automatic scan_check(input string tag);
    int    prev;
    int    len;
    bit    found;
    slot_t e;
    found = 0;
    prev  = int'(o_DigitSelect);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (prev != 0 && o_DigitSelect == 2'd0) begin
        found = 1;
        break;
      end
      prev = int'(o_DigitSelect);
    end
    if (!found) begin
      check({tag, "_sync_timeout"}, 1, 0);
      exp_q.delete();
      return;
    end
    for (int s = 0; s < 4; s++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_sel%0d", tag, s), int'(o_DigitSelect), e.sel);
      check($sformatf("%s_bcd%0d", tag, s), int'(o_bcd), e.bcd);
      check($sformatf("%s_blank%0d", tag, s), int'(o_blank), e.blank);
      len = 1;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (int'(o_DigitSelect) == e.sel) len++;
        else break;
      end
      check($sformatf("%s_len%0d", tag, s), len, 4);
    end
    check({tag, "_wrap"}, int'(o_DigitSelect), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bl;

    i_reset_n = 1'b0;
    i_value   = '0;
    i_load    = 1'b0;
    i_blank   = 1'b0;

    // Reset state and free-running scan sequence after release.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_sel",   int'(o_DigitSelect), 0);
    check("rst_bcd",   int'(o_bcd), 0);
    check("rst_blank", int'(o_blank), 1);
    check("rst_busy",  int'(o_busy), 0);
    i_reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("rst_seq%0d", k), int'(o_DigitSelect), (k / 4) % 4);
      if (k == 1) check("rel_blank", int'(o_blank), 0);
      @(negedge clk);
    end

    // Plain conversion and scan.
    load_value(1234, 0, 0, bl);
    check("busy_1234", bl, 15);
    push_expected(1234);
    scan_check("v1234");

    // Leading-zero blanking.
    load_value(7, 0, 0, bl);
    check("busy_7", bl, 15);
    push_expected(7);
    scan_check("v7");

    load_value(0, 0, 0, bl);
    push_expected(0);
    scan_check("v0");

    load_value(1005, 0, 0, bl);
    push_expected(1005);
    scan_check("v1005");

    // External blank forces digits off one cycle later and releases likewise.
    @(negedge clk);
    i_blank = 1'b1;
    @(negedge clk);
    check("iblank_on", int'(o_blank), 1);
    repeat (5) @(negedge clk);
    check("iblank_hold", int'(o_blank), 1);
    i_blank = 1'b0;
    @(negedge clk);
    check("iblank_off", int'(o_blank), 0);

    // Saturation.
    load_value(12000, 0, 0, bl);
    check("busy_12000", bl, 15);
    push_expected(12000);
    scan_check("v12000");

    // Load during busy is ignored.
    load_value(5678, 5, 1111, bl);
    check("busy_5678_inj", bl, 15);
    repeat (3) @(negedge clk);
    check("busy_after_inj", int'(o_busy), 0);
    push_expected(5678);
    scan_check("v5678");

    // Reset in the middle of a conversion.
    @(negedge clk);
    i_value = 14'd4321;
    i_load  = 1'b1;
    @(negedge clk);
    i_load  = 1'b0;
    bl = 0;
    while (o_busy === 1'b1 && bl < 40) begin
      bl++;
      if (bl == 8) break;
      @(negedge clk);
    end
    check("busy_before_rst", bl, 8);
    i_reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy",  int'(o_busy), 0);
    check("abort_sel",   int'(o_DigitSelect), 0);
    check("abort_bcd",   int'(o_bcd), 0);
    check("abort_blank", int'(o_blank), 1);
    i_reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_busy_later", int'(o_busy), 0);
    push_expected(0);
    scan_check("abort");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fnd_scan_controller.md
FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 100000, giving clock cycles per digit slot (1 kHz digit rate at 100 MHz).
REQ-002 The block SHALL have parameter LZ_BLANK, default 1, where 1 enables leading-zero blanking.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-004 The block SHALL have port i_reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port i_value, input, 14 bits: unsigned binary value to display.
REQ-006 The block SHALL have port i_load, input, 1 bit: single-cycle strobe that captures i_value.
REQ-007 The block SHALL have port i_blank, input, 1 bit: forces all digits off while high.
REQ-008 The block SHALL have port o_busy, output, 1 bit: conversion in progress.
REQ-009 The block SHALL have port o_DigitSelect, output, 2 bits: digit index, driving the select decoder's i_DigitSelect.
REQ-010 The block SHALL have port o_blank, output, 1 bit: 1 turns all digits off, driving the select decoder's i_en.
REQ-011 The block SHALL have port o_bcd, output, 4 bits: BCD value of the currently selected digit, driving the segment decoder.

Function
REQ-012 The conversion FSM SHALL have three states:
- IDLE: i_load=1 goes to CONV.
- CONV: 14 cycles of shift-add-3 (double dabble), then goes to UPDATE.
- UPDATE: copies the 4 BCD digits into the display registers, then goes to IDLE.
REQ-013 The block SHALL drive o_busy=1 exactly in CONV and UPDATE, which is 15 cycles.
REQ-014 For i_load sampled at edge t0 in IDLE, o_busy SHALL be 1 during cycles t0+1..t0+15, and the new digits SHALL be in the display registers from cycle t0+16.
REQ-015 The block SHALL ignore i_load while o_busy=1; the load is not queued.
REQ-016 The block SHALL saturate i_value greater than 9999 to 9999 at capture.
REQ-017 The prescale counter SHALL count 0..PRESCALE-1 and wrap; the block SHALL generate a one-cycle tick when the count equals PRESCALE-1.
REQ-018 The digit counter SHALL increment on each tick, wrapping from 3 to 0; it SHALL run continuously, independent of the FSM and of i_blank.
REQ-019 Digit index 0 SHALL be the ones digit and index 3 the thousands digit.
REQ-020 o_DigitSelect and o_bcd SHALL be registered and update on the same edge, so that o_bcd always equals the display digit indexed by o_DigitSelect.
REQ-021 A display-register update in UPDATE SHALL take effect on o_bcd at the next digit advance; the scan phase SHALL NOT be disturbed.
REQ-022 With LZ_BLANK=1, digit d>0 SHALL be blanked when it and every higher digit are zero; digit 0 SHALL never be leading-zero blanked, so value 0 shows "0".
REQ-023 o_blank SHALL be registered each cycle as i_blank OR (leading-zero blank of the digit being presented), and SHALL stay aligned with o_DigitSelect.

Reset
REQ-024 While i_reset_n=0 at a rising edge, the block SHALL set:
- FSM to IDLE
- shift and display registers to 0
- prescale and digit counters to 0
- o_DigitSelect=0, o_bcd=0, o_blank=1, o_busy=0
REQ-025 Reset asserted during CONV or UPDATE SHALL abort the conversion with no partial display update; o_busy SHALL be 0 on the cycle after the reset edge.
REQ-026 After reset release, o_blank SHALL follow REQ-023 from the first clock edge.

Structure
REQ-027 Shared package fnd_pkg SHALL hold:
- FSM state encoding (IDLE/CONV/UPDATE)
- NUM_DIGITS=4
- BCD_W=4
- VALUE_W=14
- MAX_VALUE=9999
- CONV_CYCLES=14
REQ-028 The double-dabble datapath and its cycle counter SHALL be one sub-module, bin2bcd_seq (start, value in; busy, done, four BCD digits out); scanning, blanking and output registers SHALL stay in the top level.

Verification (benches SHALL use PRESCALE=4)
REQ-029 Reset test: hold i_reset_n=0 for 5 cycles -> o_DigitSelect=0, o_bcd=0, o_blank=1, o_busy=0; then release -> digit counter advances every 4 cycles, sequence 0,1,2,3,0.
REQ-030 Load 1234 -> o_busy=1 for exactly 15 cycles, then the scan shows index0=4, index1=3, index2=2, index3=1 with o_blank=0, each for 4 cycles, and wraps 3->0.
REQ-031 Leading-zero test:
- Load 7 -> index0 o_bcd=7, o_blank=0; indices 1-3 o_blank=1.
- Load 0 -> index0 o_bcd=0, o_blank=0.
- Load 1005 -> no digit blanked.
REQ-032 Load 12000 -> display shows 9,9,9,9.
REQ-033 Load 5678, then pulse i_load with 1111 on busy cycle 5 -> second load ignored, display 5678, o_busy falls 15 cycles after the first load.
REQ-034 Load 4321, assert i_reset_n=0 on busy cycle 8 -> o_busy=0 next cycle, all display digits 0, o_blank=1; i_blank=1 at any time -> o_blank=1 one cycle later.
